// File: rtl/muldiv_seq.sv
// Iterative unsigned 32x32 multiply / restoring divide sharing one adder; done DATAWIDTH+1 cycles after start
// (one cycle for divide-by-zero). No backpressure: start is taken only in IDLE, otherwise dropped.

module add_suber #(
    parameter int W = 32
) (
    input  logic [W-1:0] data_A,
    input  logic [W-1:0] data_B,
    input  logic         sub_flag,
    output logic [W-1:0] result,
    output logic         co,
    output logic         zero,
    output logic         result_sign,
    output logic         overflow
);
    logic [W:0]   full;
    logic [W-1:0] b_eff;

    // Subtract is A + ~B + 1, so co=1 on subtract means no borrow.
    always_comb begin
        b_eff       = sub_flag ? ~data_B : data_B;
        full        = {1'b0, data_A} + {1'b0, b_eff} + {{W{1'b0}}, sub_flag};
        result      = full[W-1:0];
        co          = full[W];
        zero        = (result == '0);
        result_sign = result[W-1];
        overflow    = (data_A[W-1] == b_eff[W-1]) && (result[W-1] != data_A[W-1]);
    end
endmodule

module muldiv_seq #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [DATAWIDTH-1:0] op_a,
    input  logic [DATAWIDTH-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] result_lo,
    output logic [DATAWIDTH-1:0] result_hi,
    output logic                 div_by_zero
);
    localparam int W = DATAWIDTH;
    localparam logic [5:0] LAST_CNT = 6'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   m_q, m_d;
    logic [5:0]     cnt_q, cnt_d;
    logic           op_q, op_d;
    logic [W-1:0]   res_lo_q, res_lo_d;
    logic [W-1:0]   res_hi_q, res_hi_d;
    logic           dbz_q, dbz_d;

    logic [W-1:0]   acc_shl, q_shl;
    logic           shl_out;
    logic [W-1:0]   add_a, add_res;
    logic           add_co;
    logic           adder_zero_unused, adder_sign_unused, adder_ovf_unused;
    logic           mul_c;
    logic [W-1:0]   mul_sum;
    logic [W-1:0]   step_acc, step_q;

    add_suber #(.W(W)) u_add_suber (
        .data_A      (add_a),
        .data_B      (m_q),
        .sub_flag    (op_q),
        .result      (add_res),
        .co          (add_co),
        .zero        (adder_zero_unused),
        .result_sign (adder_sign_unused),
        .overflow    (adder_ovf_unused)
    );

    // One iteration of either algorithm, computed from the current registers.
    always_comb begin
        shl_out  = acc_q[W-1];
        acc_shl  = {acc_q[W-2:0], q_q[W-1]};
        q_shl    = {q_q[W-2:0], 1'b0};
        add_a    = op_q ? acc_shl : acc_q;
        mul_c    = 1'b0;
        mul_sum  = acc_q;
        step_acc = acc_q;
        step_q   = q_q;
        if (!op_q) begin
            if (q_q[0]) begin
                mul_c   = add_co;
                mul_sum = add_res;
            end
            step_acc = {mul_c, mul_sum[W-1:1]};
            step_q   = {mul_sum[0], q_q[W-1:1]};
        end else if (shl_out || add_co) begin
            step_acc = add_res;
            step_q   = {q_shl[W-1:1], 1'b1};
        end else begin
            step_acc = acc_shl;
            step_q   = q_shl;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    m_d   = op_b;
                    q_d   = op_a;
                    acc_d = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (op && (op_b == '0)) begin
                        state_d  = S_DONE;
                        res_lo_d = '1;
                        res_hi_d = op_a;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = S_DONE;
                    res_lo_d = step_q;
                    res_hi_d = step_acc;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;
endmodule
